// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux block family.
// Pure package: no logic, no latency, no flow control.
package demux_pkg;

  localparam int DEMUX_MAX_CH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Channel k of a flattened per-channel bus starts at this bit.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register; 1-cycle load-to-valid latency.
// Holds q stable while vld && !rdy; drain and load in one cycle keeps full rate.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] q,
  output logic         can_acc
);

  assign can_acc = !vld || rdy;

  // The parent only raises ld when can_acc is high, so a load always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (ld) begin
      vld <= 1'b1;
      q   <= d;
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_router.sv
// 1-to-N_CH stream demux with per-channel registered slots; 1-cycle latency, all-or-nothing broadcast.
// in_ready depends only on slot state and out_ready; DEMUX_DROP_CNT_EN adds the out-of-range drop counter.
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = clog2(N_CH),
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [DATA_W-1:0]        in_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt
`endif
);

  logic [N_CH-1:0] can_acc;
  logic [N_CH-1:0] ld;
  logic            sel_oor;
  logic            beat_acc;

  // With a power-of-two channel count every select value names a real channel.
  if ((1 << SEL_W) == N_CH) begin : g_sel_pow2
    assign sel_oor = 1'b0;
  end else begin : g_sel_npow2
    assign sel_oor = (in_sel >= SEL_W'(N_CH));
  end

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)      in_ready = &can_acc;
    else if (!sel_oor) in_ready = can_acc[in_sel];
  end

  assign beat_acc = in_valid && in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ld[k] = beat_acc && (in_bcast || (!sel_oor && (in_sel == SEL_W'(k))));

    demux_slot #(.W(DATA_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld[k]),
      .d       (in_data),
      .rdy     (out_ready[k]),
      .vld     (out_valid[k]),
      .q       (out_data[ch_lsb(k, DATA_W) +: DATA_W]),
      .can_acc (can_acc[k])
    );
  end

`ifdef DEMUX_DROP_CNT_EN
  logic drop_inc;
  assign drop_inc = in_valid && !in_bcast && sel_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_inc && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench: directed scenarios plus a random soak against a per-channel queue model (N_CH=4),
// and a second N_CH=3 instance for out-of-range beats and the optional drop counter.
module tb_demux_stream_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;

  logic        v3;
  logic        rdy3;
  logic [1:0]  sel3;
  logic        bcast3;
  logic [7:0]  data3;
  logic [2:0]  ov3;
  logic [2:0]  ordy3;
  logic [23:0] od3;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] dc4;
  logic [1:0]  dc3;
`endif

  int checks;
  int errors;

  logic [7:0] sb [4][$];

  demux_stream_router #(.DATA_W(8), .N_CH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (dc4)
`endif
  );

  demux_stream_router #(.DATA_W(8), .N_CH(3), .CNT_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v3),
    .in_ready  (rdy3),
    .in_sel    (sel3),
    .in_bcast  (bcast3),
    .in_data   (data3),
    .out_valid (ov3),
    .out_ready (ordy3),
    .out_data  (od3)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (dc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each channel is a queue of beats owed to its consumer.
  task automatic model_step();
    logic [3:0] can;
    logic       exp_rdy;
    if (rst) begin
      for (int k = 0; k < 4; k++) sb[k].delete();
      return;
    end
    for (int k = 0; k < 4; k++) can[k] = (sb[k].size() == 0) || out_ready[k];
    exp_rdy = in_bcast ? (&can) : can[in_sel];
    chk("in_ready", in_ready, exp_rdy);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), out_valid[k], sb[k].size() != 0);
      if (sb[k].size() != 0)
        chk($sformatf("out_data[%0d]", k), out_data[k*8 +: 8], sb[k][0]);
    end
    for (int k = 0; k < 4; k++)
      if (sb[k].size() != 0 && out_ready[k]) void'(sb[k].pop_front());
    if (in_valid && exp_rdy)
      for (int k = 0; k < 4; k++)
        if (in_bcast || in_sel == k) sb[k].push_back(in_data);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] dat);
    in_valid = 1'b1;
    in_bcast = 1'b0;
    in_sel   = sel;
    in_data  = dat;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = 4'hF;
    v3 = 1'b0; sel3 = '0; bcast3 = 1'b0; data3 = '0; ordy3 = 3'b111;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_valid", out_valid, 4'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset3_valid", ov3, 3'b000);
`ifdef DEMUX_DROP_CNT_EN
    chk("reset_drop", dc3, 2'd0);
`endif

    // Unicast back-to-back
    send(2'd0, 8'h11); #1 chk("uni_rdy0", in_ready, 1'b1); cycle();
    send(2'd2, 8'h22); #1 chk("uni_rdy1", in_ready, 1'b1); cycle();
    chk("uni_ch0", out_data[7:0], 8'h11);
    send(2'd3, 8'h33); #1 chk("uni_rdy2", in_ready, 1'b1); cycle();
    chk("uni_ch2", out_data[23:16], 8'h22);
    in_valid = 1'b0;
    cycle();
    chk("uni_ch3", out_data[31:24], 8'h33);

    // Backpressure on channel 1, then drain+load on release
    out_ready = 4'b1101;
    send(2'd1, 8'hA5); cycle();
    in_data = 8'h5A;
    #1 chk("bp_rdy_low", in_ready, 1'b0);
    chk("bp_hold", out_data[15:8], 8'hA5);
    cycle();
    cycle();
    chk("bp_hold2", out_data[15:8], 8'hA5);
    out_ready = 4'hF;
    #1 chk("bp_rdy_release", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    #1 chk("bp_valid_kept", out_valid[1], 1'b1);
    chk("bp_new_data", out_data[15:8], 8'h5A);
    cycle();

    // Broadcast blocked by a stalled slot 2
    out_ready = 4'b1011;
    send(2'd2, 8'h99); cycle();
    in_bcast = 1'b1; in_data = 8'h7E;
    #1 chk("bc_rdy_low", in_ready, 1'b0);
    cycle();
    cycle();
    out_ready = 4'hF;
    #1 chk("bc_rdy_high", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0; in_bcast = 1'b0;
    #1 chk("bc_valid", out_valid, 4'hF);
    chk("bc_data", out_data, {4{8'h7E}});
    cycle();

    // Reset with stalled channels 0 and 2
    out_ready = 4'b1010;
    send(2'd0, 8'h01); cycle();
    send(2'd2, 8'h02); cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", out_valid & 4'b0101, 4'b0101);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rst_valid", out_valid, 4'h0);
    chk("rst_data", out_data, 32'h0);
    out_ready = 4'hF;
    send(2'd0, 8'h44);
    #1 chk("post_rst_rdy", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    #1 chk("post_rst_valid", out_valid, 4'h1);
    chk("post_rst_data", out_data[7:0], 8'h44);
    cycle();

    // Out-of-range beats on the 3-channel instance
    v3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 5; i++) begin
      data3 = 8'(i + 8'hC0);
      #1 chk("oor_rdy", rdy3, 1'b1);
      cycle();
      chk("oor_no_valid", ov3, 3'b000);
`ifdef DEMUX_DROP_CNT_EN
      chk("oor_drop_cnt", dc3, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
`endif
    end
    sel3 = 2'd1; data3 = 8'h5C;
    cycle();
    bcast3 = 1'b1; sel3 = 2'd3; data3 = 8'hB3;
    #1 chk("ch3_inrange_valid", ov3, 3'b010);
    chk("ch3_inrange_data", od3[15:8], 8'h5C);
    cycle();
    v3 = 1'b0; bcast3 = 1'b0;
    #1 chk("ch3_bcast_valid", ov3, 3'b111);
    chk("ch3_bcast_data", od3, {3{8'hB3}});
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("ch3_rst_valid", ov3, 3'b000);
`ifdef DEMUX_DROP_CNT_EN
    chk("ch3_rst_drop", dc3, 2'd0);
`endif

    // Random soak
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 2'($urandom_range(3));
      in_bcast  = ($urandom_range(7) == 0);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom) | 4'($urandom);
      cycle();
    end
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'hF;
    cycle();
    cycle();
    cycle();
    chk("drain_valid", out_valid, 4'h0);
    chk("drain_model_empty", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
